// File: rtl/spike_stim_gen.sv
// spike_stim_gen: multi-channel spike stimulus generator for SNN neuron arrays.
// A command loads one scene (idle, delayed step, periodic burst or per-channel
// LFSR random). The scene plays for cmd_duration cycles on the registered spike
// outputs, then a one-cycle FIN state pulses done. A running tally counts every
// asserted spike bit and saturates at its maximum.
module spike_stim_gen #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_duration,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic [CNT_W-1:0] cmd_burst_len,
  input  logic [15:0]      cmd_thresh,
  input  logic [15:0]      cmd_seed,
  input  logic [N_CH-1:0]  cmd_mask,
  input  logic [N_CH-1:0]  cmd_pulse_mask,
  input  logic             abort,
  output logic [N_CH-1:0]  spike,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] scene_cycle,
  output logic [CNT_W-1:0] spike_tally
);

  localparam logic [1:0]       MODE_IDLE   = 2'd0;
  localparam logic [1:0]       MODE_STEP   = 2'd1;
  localparam logic [1:0]       MODE_BURST  = 2'd2;
  localparam logic [1:0]       MODE_RANDOM = 2'd3;
  localparam logic [15:0]      LFSR_TAPS   = 16'hB400;
  localparam int               POP_W       = $clog2(N_CH + 1);
  // Wide enough that max tally plus a full popcount cannot wrap.
  localparam int               SUM_W       = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] TALLY_MAX   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  state_t state_reg, state_next;
  logic   accept;
  logic   finish;

  // Command fields captured at the accept edge.
  logic [1:0]       mode_reg;
  logic [CNT_W-1:0] duration_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] burst_len_reg;
  logic [15:0]      thresh_reg;
  logic [N_CH-1:0]  mask_reg;
  logic [N_CH-1:0]  pulse_mask_reg;

  // Scene progress: index i, burst phase p and one LFSR per channel.
  logic [CNT_W-1:0]      idx_reg;
  logic [CNT_W-1:0]      phase_reg;
  logic [N_CH-1:0][15:0] lfsr_reg;
  logic [N_CH-1:0][15:0] lfsr_seed;
  logic [N_CH-1:0][15:0] lfsr_adv;
  logic [N_CH-1:0][15:0] src_lfsr;

  logic [N_CH-1:0]  spike_reg;
  logic             done_reg;
  logic             aborted_reg;
  logic [CNT_W-1:0] tally_reg;
  logic [CNT_W-1:0] tally_next;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] tally_sum;

  // Pattern source: values describing the cycle that follows the next edge.
  // At accept they come straight from the command; in RUN from latched state.
  logic [1:0]       src_mode;
  logic [CNT_W-1:0] src_period;
  logic [CNT_W-1:0] src_half;
  logic [CNT_W-1:0] src_burst_len;
  logic [15:0]      src_thresh;
  logic [N_CH-1:0]  src_mask;
  logic [N_CH-1:0]  src_pulse_mask;
  logic [CNT_W-1:0] src_idx;
  logic [CNT_W-1:0] src_phase;
  logic [CNT_W-1:0] phase_last;
  logic [CNT_W-1:0] last_idx;
  logic [N_CH-1:0]  pattern_next;

  // Phase wraps at max(period,1)-1; P>>1 equals period>>1 for both cases.
  assign phase_last = (period_reg == '0) ? '0 : period_reg - 1'b1;
  assign last_idx   = duration_reg - 1'b1;
  assign src_half   = src_period >> 1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic with accept/finish strobes for the datapath.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = (cmd_duration == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort || (idx_reg == last_idx)) begin
          finish     = 1'b1;
          state_next = ST_FIN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the operands for the pattern of the upcoming cycle.
  always_comb begin
    src_mode       = mode_reg;
    src_period     = period_reg;
    src_burst_len  = burst_len_reg;
    src_thresh     = thresh_reg;
    src_mask       = mask_reg;
    src_pulse_mask = pulse_mask_reg;
    src_idx        = idx_reg + 1'b1;
    src_phase      = (phase_reg >= phase_last) ? '0 : phase_reg + 1'b1;
    if (accept) begin
      src_mode       = cmd_mode;
      src_period     = cmd_period;
      src_burst_len  = cmd_burst_len;
      src_thresh     = cmd_thresh;
      src_mask       = cmd_mask;
      src_pulse_mask = cmd_pulse_mask;
      src_idx        = '0;
      src_phase      = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      localparam logic [31:0] SEED_PROD = 32'(gi) * 32'h0000_9E37;
      logic [15:0] seed_raw;
      logic        chan_bit;

      // Per-channel decorrelated seed; the all-zero LFSR lock-up state is avoided.
      assign seed_raw       = cmd_seed ^ SEED_PROD[15:0];
      assign lfsr_seed[gi]  = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;
      assign lfsr_adv[gi]   = {1'b0, lfsr_reg[gi][15:1]} ^ (lfsr_reg[gi][0] ? LFSR_TAPS : 16'h0000);
      assign src_lfsr[gi]   = accept ? lfsr_seed[gi] : lfsr_adv[gi];

      // Unmasked pattern bit of this channel for the upcoming cycle.
      always_comb begin
        chan_bit = 1'b0;
        case (src_mode)
          MODE_IDLE:   chan_bit = 1'b0;
          MODE_STEP:   chan_bit = (src_idx >= src_period);
          MODE_BURST:  chan_bit = src_pulse_mask[gi] ? ((src_phase == '0) || (src_phase == src_half))
                                                     : (src_phase < src_burst_len);
          MODE_RANDOM: chan_bit = (src_lfsr[gi] < src_thresh);
          default:     chan_bit = 1'b0;
        endcase
      end

      assign pattern_next[gi] = chan_bit & src_mask[gi];
    end
  endgenerate

  // Popcount of the current spike vector and saturating accumulation.
  always_comb begin
    pop = '0;
    for (int k = 0; k < N_CH; k++) pop = pop + POP_W'(spike_reg[k]);
    tally_sum  = SUM_W'(tally_reg) + SUM_W'(pop);
    tally_next = (tally_sum > SUM_W'(TALLY_MAX)) ? TALLY_MAX : tally_sum[CNT_W-1:0];
  end

  // Scene datapath: latch command, step index/phase/LFSRs, register spikes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg       <= MODE_IDLE;
      duration_reg   <= '0;
      period_reg     <= '0;
      burst_len_reg  <= '0;
      thresh_reg     <= '0;
      mask_reg       <= '0;
      pulse_mask_reg <= '0;
      idx_reg        <= '0;
      phase_reg      <= '0;
      lfsr_reg       <= {N_CH{16'h0001}};
      spike_reg      <= '0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      tally_reg      <= '0;
    end else begin
      tally_reg   <= tally_next;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mode_reg       <= cmd_mode;
            duration_reg   <= cmd_duration;
            period_reg     <= cmd_period;
            burst_len_reg  <= cmd_burst_len;
            thresh_reg     <= cmd_thresh;
            mask_reg       <= cmd_mask;
            pulse_mask_reg <= cmd_pulse_mask;
            lfsr_reg       <= lfsr_seed;
            idx_reg        <= '0;
            phase_reg      <= '0;
            if (cmd_duration == '0) begin
              // Empty scene goes straight to FIN.
              spike_reg <= '0;
              done_reg  <= 1'b1;
            end else begin
              spike_reg <= pattern_next;
            end
          end
        end
        ST_RUN: begin
          lfsr_reg <= lfsr_adv;
          if (finish) begin
            spike_reg   <= '0;
            idx_reg     <= '0;
            phase_reg   <= '0;
            done_reg    <= 1'b1;
            aborted_reg <= abort;
          end else begin
            spike_reg <= pattern_next;
            idx_reg   <= src_idx;
            phase_reg <= src_phase;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg == ST_RUN);
  assign spike       = spike_reg;
  assign done        = done_reg;
  assign aborted     = aborted_reg;
  assign scene_cycle = idx_reg;
  assign spike_tally = tally_reg;

endmodule
